// File: rtl/program_loader_rom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : program_loader_rom_pkg                                 |
// | Description : Shared types and constants for the program loader ROM. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package program_loader_rom_pkg;

  localparam int LOAD_NIBBLE_W = 4;
  localparam int PROG_DEPTH    = 16;
  localparam int INSTR_BITS    = 8;

  // CPU instruction word; the loader's INSTR_W must match its width.
  typedef logic [INSTR_BITS-1:0] instruction_t;

  // Loader sequencing states, explicitly encoded in 3 bits.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader_rom_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : program_memory                                         |
// | Description : DEPTH x INSTR_W register array with one synchronous    |
// |               write port, one asynchronous read port and an          |
// |               asynchronous active-low clear.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module program_memory #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Storage: cleared on reset, otherwise written one word per enabled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/program_loader_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : program_loader_rom                                     |
// | Description : Loads a checksummed program as a nibble stream, stores |
// |               it for the CPU fetch port and holds the CPU in reset   |
// |               until a load completes cleanly.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module program_loader_rom
  import program_loader_rom_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = PROG_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [LOAD_NIBBLE_W-1:0] load_data,
  input  logic [3:0]               instruction_addr,
  output logic [INSTR_W-1:0]       instruction,
  output logic                     cpu_reset,
  output logic                     load_done,
  output logic                     load_error
);

  localparam int c_NPI  = INSTR_W / LOAD_NIBBLE_W;
  localparam int c_NC_W = (c_NPI > 1) ? $clog2(c_NPI) : 1;
  localparam logic [c_NC_W-1:0] c_LAST_NIB = c_NC_W'(c_NPI - 1);

  loader_state_t            r_state;
  loader_state_t            w_state_next;
  logic [3:0]               r_count;
  logic [3:0]               r_wr_addr;
  logic [c_NC_W-1:0]        r_nib_cnt;
  logic [INSTR_W-1:0]       r_shift;
  logic [LOAD_NIBBLE_W-1:0] r_acc;

  logic                     w_ready;
  logic                     w_xfer;
  logic                     w_word_done;
  logic                     w_mem_we;
  logic [INSTR_W-1:0]       w_asm;
  logic [INSTR_W-1:0]       w_rdata;

  // The block only listens to the stream while a load is in progress.
  assign w_ready     = (r_state == HEADER) || (r_state == DATA) || (r_state == CHECK);
  assign load_ready  = w_ready;
  assign w_xfer      = load_valid && w_ready;
  assign w_word_done = (r_nib_cnt == c_LAST_NIB);
  // Newest nibble lands in the low bits, so the first nibble ends up as the MSBs.
  assign w_asm       = (r_shift << LOAD_NIBBLE_W) | INSTR_W'(load_data);
  // A restart request wins over a coincident nibble, so the write is suppressed.
  assign w_mem_we    = w_xfer && !load_start && (r_state == DATA) && w_word_done;

  // State register and loader datapath (count, address, assembler, checksum).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_wr_addr <= '0;
      r_nib_cnt <= '0;
      r_shift   <= '0;
      r_acc     <= '0;
    end else begin
      r_state <= w_state_next;
      if (load_start) begin
        r_wr_addr <= '0;
        r_nib_cnt <= '0;
        r_acc     <= '0;
      end else if (w_xfer) begin
        case (r_state)
          HEADER: begin
            r_count <= load_data;
            r_acc   <= load_data;
          end
          DATA: begin
            r_acc   <= r_acc ^ load_data;
            r_shift <= w_asm;
            if (w_word_done) begin
              r_nib_cnt <= '0;
              // Hold at the last address instead of wrapping past count.
              if (r_wr_addr != r_count) begin
                r_wr_addr <= r_wr_addr + 4'd1;
              end
            end else begin
              r_nib_cnt <= r_nib_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_next = r_state;
    cpu_reset    = 1'b1;
    load_done    = 1'b0;
    load_error   = 1'b0;

    if (load_start) begin
      w_state_next = HEADER;
    end else begin
      case (r_state)
        IDLE:   w_state_next = IDLE;
        HEADER: if (load_valid) w_state_next = DATA;
        DATA:   if (w_mem_we && (r_wr_addr == r_count)) w_state_next = CHECK;
        CHECK:  if (load_valid) w_state_next = (load_data == r_acc) ? RUN : ERROR;
        RUN:    w_state_next = RUN;
        ERROR:  w_state_next = ERROR;
        default: w_state_next = IDLE;
      endcase
    end

    case (r_state)
      RUN: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  program_memory #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .ADDR_W  (4)
  ) u_program_memory (
    .clk   (clk),
    .reset (reset),
    .we    (w_mem_we),
    .waddr (r_wr_addr),
    .wdata (w_asm),
    .raddr (instruction_addr),
    .rdata (w_rdata)
  );

  // Fetch path: entries beyond the loaded count read as NOP, and nothing leaks outside RUN.
  assign instruction = ((r_state == RUN) && (instruction_addr <= r_count)) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_program_loader_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_program_loader_rom                                  |
// | Description : Scoreboard bench for program_loader_rom.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_program_loader_rom;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = 4'h0;
  logic [3:0] instruction_addr = 4'h0;
  logic       load_ready;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic       load_done;
  logic       load_error;

  typedef struct {
    string      name;
    logic [3:0] addr;
    logic [7:0] instr;
    logic       done;
    logic       err;
    logic       crst;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  program_loader_rom #(
    .INSTR_W (8),
    .DEPTH   (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .instruction_addr (instruction_addr),
    .instruction      (instruction),
    .cpu_reset        (cpu_reset),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  // Monitor: compare every pending expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (instruction !== e.instr || load_done !== e.done || load_error !== e.err ||
          cpu_reset !== e.crst || load_ready !== e.ready) begin
        fails++;
        $display("FAIL %s addr=%h: got instr=%h done=%b err=%b cpu_reset=%b ready=%b, expected instr=%h done=%b err=%b cpu_reset=%b ready=%b",
                 e.name, e.addr, instruction, load_done, load_error, cpu_reset, load_ready,
                 e.instr, e.done, e.err, e.crst, e.ready);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [3:0] a, input logic [7:0] ins,
                          input logic d, input logic er, input logic c, input logic r);
    exp_t x;
    instruction_addr = a;
    x.name = nm; x.addr = a; x.instr = ins;
    x.done = d; x.err = er; x.crst = c; x.ready = r;
    exp_q.push_back(x);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] a, input logic [7:0] ins,
                            input logic d, input logic er, input logic c, input logic r);
    push_exp(nm, a, ins, d, er, c, r);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Offer one nibble; with gaps, valid first drops for a random 1-2 cycles while data holds.
  task automatic send(input logic [3:0] n, input bit gaps);
    int b;
    load_data = n;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      load_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    load_valid = 1'b1;
    b = 0;
    while (!load_ready && b < 20) begin @(posedge clk); #1; b++; end
    if (!load_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: load_ready stayed 0 for nibble %h, required 1", n);
    end else begin
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  // Header 1, instructions 0x3A and 0x5C, then the given checksum (correct value is 1).
  task automatic basic_stream(input logic [3:0] csum, input bit gaps);
    logic [3:0] s [6];
    s = '{4'h1, 4'h3, 4'hA, 4'h5, 4'hC, csum};
    for (int i = 0; i < 6; i++) send(s[i], gaps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a nibble offered that must be ignored.
    repeat (2) @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = 4'h5;
    expect_out("reset_state", 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    expect_out("idle_ignores_valid", 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    load_valid = 1'b0;

    // Basic load.
    pulse_start();
    basic_stream(4'h1, 1'b0);
    expect_out("basic_addr0",  4'h0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("basic_addr1",  4'h1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("basic_addr2",  4'h2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("basic_addr15", 4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Nibbles offered in RUN must not be taken.
    load_valid = 1'b1;
    load_data  = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    load_valid = 1'b0;
    expect_out("run_ignores_valid", 4'h0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Checksum mismatch.
    pulse_start();
    basic_stream(4'h0, 1'b0);
    expect_out("bad_csum_addr0",  4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("bad_csum_addr1",  4'h1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("bad_csum_addr15", 4'hF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

    // Backpressure and gaps in load_valid.
    pulse_start();
    basic_stream(4'h1, 1'b1);
    expect_out("gaps_addr0", 4'h0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("gaps_addr1", 4'h1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("gaps_addr2", 4'h2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Full depth: 16 instructions 0x00..0x0F, checksum F ^ 0 = F.
    pulse_start();
    send(4'hF, 1'b0);
    for (int k = 0; k < 16; k++) begin
      send(4'h0, 1'b0);
      send(4'(k), 1'b0);
    end
    expect_out("full_in_check", 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    send(4'hF, 1'b0);
    for (int k = 0; k < 16; k++) begin
      expect_out($sformatf("full_addr%0d", k), 4'(k), 8'(k), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // load_start in RUN drops back to HEADER with cpu_reset raised.
    pulse_start();
    expect_out("start_in_run", 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Abort after 3 data nibbles (mem[0] gets 0x77), restart with a coincident nibble.
    send(4'h1, 1'b0);
    send(4'h7, 1'b0);
    send(4'h7, 1'b0);
    send(4'h7, 1'b0);
    load_valid = 1'b1;
    load_data  = 4'h7;
    pulse_start();
    load_valid = 1'b0;
    basic_stream(4'h1, 1'b0);
    expect_out("reload_addr0", 4'h0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("reload_addr1", 4'h1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("reload_addr2", 4'h2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during DATA, released before the next clock edge.
    pulse_start();
    send(4'h1, 1'b0);
    send(4'h3, 1'b0);
    send(4'hA, 1'b0);
    send(4'h5, 1'b0);
    reset = 1'b0;
    push_exp("async_reset_now", 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    #6;
    reset = 1'b1;
    @(posedge clk); #1;
    expect_out("after_reset_idle", 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Recovery after reset.
    pulse_start();
    basic_stream(4'h1, 1'b0);
    expect_out("recover_addr1", 4'h1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader_rom.md
Name: program_loader_rom

Overview:
- Instruction-side responder for the 4-bit CPU fetch interface: it returns `instruction` for the CPU's `instruction_addr` output.
- Before the CPU runs, the block accepts a program as a 4-bit nibble stream over a valid/ready handshake.
- It assembles the nibbles into instructions, stores them in a 16-entry memory and verifies an XOR checksum.
- It holds the CPU in reset until a load completes cleanly.

Parameters:
- INSTR_W, 8, instruction width in bits; must equal $bits(instruction_t) and be a multiple of 4.
- DEPTH, 16, number of program entries; fixed by the 4-bit instruction address.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle pulse that begins a new program load, from any state.
- load_valid  input  1  load_data holds a valid nibble.
- load_ready  output  1  block accepts a nibble this cycle.
- load_data  input  4  program nibble, MSB-first within each instruction.
- instruction_addr  input  4  CPU fetch address.
- instruction  output  INSTR_W  fetched instruction (instruction_t), combinational from memory.
- cpu_reset  output  1  active-high hold into the CPU reset; integration maps it to the CPU's reset polarity.
- load_done  output  1  program loaded and verified; CPU running.
- load_error  output  1  checksum mismatch on the last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - Enters IDLE and clears all memory entries to 0.
  - Clears the count, address and nibble counters, and the checksum accumulator.
  - Outputs: cpu_reset=1, load_ready=0, load_done=0, load_error=0, instruction=0.
- Transfer rule: a transfer occurs on a rising clk when load_valid && load_ready. load_data must stay stable while load_valid=1 and load_ready=0. Nibbles arriving with load_ready=0 are ignored.
- Nibbles per instruction: NPI = INSTR_W/4.
- FSM states: IDLE, HEADER, DATA, CHECK, RUN, ERROR.
  - IDLE: load_ready=0, cpu_reset=1. load_start goes to HEADER.
  - HEADER:
    - load_ready=1.
    - One transfer captures count = load_data (number of instructions minus 1, range 0..15).
    - The accumulator is loaded with load_data, and the state goes to DATA.
  - DATA:
    - load_ready=1.
    - Each transfer shifts the nibble into a shift register and XORs it into the accumulator.
    - On the NPI-th nibble, {shift, nibble} is written to mem[wr_addr] in the same cycle; wr_addr then increments and the nibble counter resets.
    - After the write at wr_addr == count, the state goes to CHECK. No write ever targets an address above count.
  - CHECK: load_ready=1. One transfer compares load_data with the accumulator.
    - Equal: go to RUN.
    - Unequal: go to ERROR.
  - RUN: load_ready=0, cpu_reset=0, load_done=1.
    - instruction = mem[instruction_addr] when instruction_addr <= count.
    - instruction = 0 (NOP) when instruction_addr > count.
  - ERROR: load_ready=0, cpu_reset=1, load_error=1, instruction=0.
- Outside RUN, instruction=0.
- load_start in any state (including mid-DATA, RUN and ERROR):
  - Goes to HEADER on the next edge and clears wr_addr, the nibble counter and the accumulator.
  - Clears load_done and load_error, and sets cpu_reset=1.
  - Memory is not cleared; stale entries are masked by the count rule.
- load_start has priority over a simultaneous transfer; that nibble is discarded.
- Counters: the address counter is 4-bit and never wraps. With count=15, the write at address 15 exits to CHECK.

Decomposition:
- custom_types package additions:
  - loader_state_t enum {IDLE, HEADER, DATA, CHECK, RUN, ERROR}.
  - LOAD_NIBBLE_W = 4.
  - PROG_DEPTH = 16.
  - instruction_t, which is reused.
- One sub-module, program_memory:
  - DEPTH x INSTR_W register array.
  - Single synchronous write port (we, waddr, wdata) and one asynchronous read port.
  - Asynchronous active-low clear.
- The FSM, assembler and checksum logic live in program_loader_rom.

Test Plan:
- Basic load:
  - Stimulus (INSTR_W=8): load_start, then nibbles 1, 3, A, 5, C, checksum 1.
  - Response: load_done=1, cpu_reset=0; addr0 → 0x3A, addr1 → 0x5C, addr2 → 0x00, addr15 → 0x00.
- Checksum mismatch:
  - Stimulus: same stream with checksum 0.
  - Response: load_error=1, load_done=0, cpu_reset=1, instruction=0 for every address.
- Backpressure and gaps:
  - Stimulus: basic load with load_valid toggling 1-0-0-1 randomly and data held stable.
  - Response: identical memory contents; no transfer while load_valid=0 and none in IDLE or RUN.
- Full depth:
  - Stimulus: header F and 16 instructions 0x00..0x0F with the correct checksum.
  - Response: addr k → k for k = 0..15; CHECK entered only after the 32nd data nibble.
- Abort and reload:
  - Stimulus: load_start after 3 data nibbles, then the basic stream.
  - Response: only the new program is visible and load_done=1.
  - Also: load_start in RUN must raise cpu_reset within 1 cycle.
- Asynchronous reset mid-DATA:
  - Stimulus: reset=0 for a partial clock period.
  - Response: immediate IDLE, cpu_reset=1, load_ready=0, all memory 0 after release.
